// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and port identifiers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } arb_port_t;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
    localparam int LAT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (CPU, debug) and memory-macro signals of the arbiter, bundled as one interface.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic              dbg_done;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_done, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment side: requesters plus the memory macro.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_done, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr2.sv
// Combinational 2-way round-robin pick; elig_i is indexed by arb_port_t value.
module mem_arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] elig_i,
    input  arb_port_t  last_i,
    output logic       valid_o,
    output arb_port_t  winner_o
);

    always_comb begin
        valid_o  = |elig_i;
        winner_o = PORT_CPU;
        case (elig_i)
            2'b01:   winner_o = PORT_CPU;
            2'b10:   winner_o = PORT_DBG;
            2'b11:   winner_o = (last_i == PORT_CPU) ? PORT_DBG : PORT_CPU;
            default: winner_o = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory between the CPU datapath and the debug/loader port,
// one access at a time, with a one-cycle done pulse per completed access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    arb_port_t         owner_q, last_q, winner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LAT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic [1:0]        elig;
    logic              gnt_valid;

    // Bit 0 is the CPU, bit 1 debug, matching the arb_port_t encoding.
    assign elig[0] = bus.cpu_req & ~bus.dbg_lock;
    assign elig[1] = bus.dbg_req;

    mem_arb_rr2 u_rr (
        .elig_i   (elig),
        .last_i   (last_q),
        .valid_o  (gnt_valid),
        .winner_o (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (gnt_valid) state_d = ARB_ACCESS;
            ARB_ACCESS: state_d = we_q ? ARB_RESP : ARB_WAIT;
            ARB_WAIT:   if (cnt_q == '0) state_d = ARB_RESP;
            ARB_RESP:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // Qualifiers are latched only at grant so requesters may change them afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= PORT_CPU;
            last_q      <= PORT_DBG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (state_q == ARB_IDLE && gnt_valid) begin
                owner_q <= winner;
                last_q  <= winner;
                if (winner == PORT_CPU) begin
                    we_q    <= bus.cpu_we;
                    addr_q  <= bus.cpu_addr;
                    wdata_q <= bus.cpu_wdata;
                end else begin
                    we_q    <= bus.dbg_we;
                    addr_q  <= bus.dbg_addr;
                    wdata_q <= bus.dbg_wdata;
                end
            end
            if (state_q == ARB_ACCESS)
                cnt_q <= LAT_M1;
            else if (state_q == ARB_WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (state_q == ARB_WAIT && cnt_q == '0) begin
                if (owner_q == PORT_CPU) cpu_rdata_q <= bus.mem_rdata;
                else                     dbg_rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.cpu_gnt   = (state_q != ARB_IDLE) && (owner_q == PORT_CPU);
        bus.dbg_gnt   = (state_q != ARB_IDLE) && (owner_q == PORT_DBG);
        bus.cpu_done  = (state_q == ARB_RESP) && (owner_q == PORT_CPU);
        bus.dbg_done  = (state_q == ARB_RESP) && (owner_q == PORT_DBG);
        bus.cpu_rdata = cpu_rdata_q;
        bus.dbg_rdata = dbg_rdata_q;
        bus.mem_en    = (state_q == ARB_ACCESS);
        bus.mem_we    = (state_q == ARB_ACCESS) && we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=1 instance for most scenarios, MEM_LAT=3 for the slow read.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          lock_phase = 1'b0;
    exp_t        sb_cpu[$];
    exp_t        sb_dbg[$];
    logic [15:0] shadow[256];
    logic [15:0] exp_rd[2];
    logic [15:0] mem1[256];
    logic [15:0] mem3[256];
    logic [15:0] p3a, p3b;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory macros; 16'hDEAD marks cycles where read data is not valid.
    always @(posedge clk) begin
        if (if1.mem_en && if1.mem_we) mem1[if1.mem_addr[7:0]] <= if1.mem_wdata;
        if1.mem_rdata <= (if1.mem_en && !if1.mem_we) ? mem1[if1.mem_addr[7:0]] : 16'hDEAD;
    end

    always @(posedge clk) begin
        if (if3.mem_en && if3.mem_we) mem3[if3.mem_addr[7:0]] <= if3.mem_wdata;
        p3a           <= (if3.mem_en && !if3.mem_we) ? mem3[if3.mem_addr[7:0]] : 16'hDEAD;
        p3b           <= p3a;
        if3.mem_rdata <= p3b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if1.cpu_done === 1'b1) begin
            if (sb_cpu.size() == 0) chk("cpu_unexpected_done", 1, 0);
            else begin
                e = sb_cpu.pop_front();
                chk("cpu_done_cycle", cyc, e.cyc);
                chk("cpu_rdata", if1.cpu_rdata, e.data);
            end
        end
        if (if1.dbg_done === 1'b1) begin
            if (sb_dbg.size() == 0) chk("dbg_unexpected_done", 1, 0);
            else begin
                e = sb_dbg.pop_front();
                chk("dbg_done_cycle", cyc, e.cyc);
                chk("dbg_rdata", if1.dbg_rdata, e.data);
            end
        end
        if (if1.cpu_gnt === 1'b1 || if1.dbg_gnt === 1'b1)
            chk("gnt_mutex", if1.cpu_gnt & if1.dbg_gnt, 0);
        if (lock_phase) chk("lock_cpu_gnt", if1.cpu_gnt, 0);
    end

    task automatic wait_done(input bit port);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = port ? if1.dbg_done : if1.cpu_done;
        end
        if (!seen) chk(port ? "dbg_timeout" : "cpu_timeout", 0, 1);
        if (port) if1.dbg_req = 1'b0;
        else      if1.cpu_req = 1'b0;
    endtask

    // Issue at the current negedge (an IDLE cycle); lat is the expected cycles to done.
    task automatic access(input bit port, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat);
        exp_t e;
        e.cyc = cyc + lat;
        if (we) begin
            shadow[addr[7:0]] = wdata;
            e.data = exp_rd[port];
        end else begin
            e.data = shadow[addr[7:0]];
            exp_rd[port] = e.data;
        end
        if (port) begin
            sb_dbg.push_back(e);
            if1.dbg_req = 1'b1; if1.dbg_we = we; if1.dbg_addr = addr; if1.dbg_wdata = wdata;
        end else begin
            sb_cpu.push_back(e);
            if1.cpu_req = 1'b1; if1.cpu_we = we; if1.cpu_addr = addr; if1.cpu_wdata = wdata;
        end
        wait_done(port);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0; mem3[i] = 16'h0; shadow[i] = 16'h0;
        end
        mem1[8'h40] = 16'hBEEF; shadow[8'h40] = 16'hBEEF;
        mem3[8'hFF] = 16'h5A5A;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        if1.cpu_req = 0; if1.cpu_we = 0; if1.cpu_addr = 0; if1.cpu_wdata = 0;
        if1.dbg_req = 0; if1.dbg_we = 0; if1.dbg_addr = 0; if1.dbg_wdata = 0; if1.dbg_lock = 0;
        if3.cpu_req = 0; if3.cpu_we = 0; if3.cpu_addr = 0; if3.cpu_wdata = 0;
        if3.dbg_req = 0; if3.dbg_we = 0; if3.dbg_addr = 0; if3.dbg_wdata = 0; if3.dbg_lock = 0;

        repeat (3) @(negedge clk);
        chk("rst_cpu_gnt",   if1.cpu_gnt, 0);
        chk("rst_dbg_gnt",   if1.dbg_gnt, 0);
        chk("rst_cpu_done",  if1.cpu_done, 0);
        chk("rst_dbg_done",  if1.dbg_done, 0);
        chk("rst_cpu_rdata", if1.cpu_rdata, 0);
        chk("rst_dbg_rdata", if1.dbg_rdata, 0);
        chk("rst_mem_en",    if1.mem_en, 0);
        chk("rst_mem_we",    if1.mem_we, 0);
        chk("rst_mem_addr",  if1.mem_addr, 0);
        chk("rst_mem_wdata", if1.mem_wdata, 0);
        rst = 1'b0;

        // First tie after reset goes to the CPU, then debug.
        fork
            access(1'b0, 1'b1, 16'h0010, 16'h1111, 2);
            access(1'b1, 1'b1, 16'h0020, 16'h2222, 5);
        join
        @(negedge clk);
        fork
            access(1'b0, 1'b1, 16'h0011, 16'h3333, 2);
            access(1'b1, 1'b1, 16'h0021, 16'h4444, 5);
        join
        @(negedge clk);

        // Lone CPU read with memory bus checks.
        fork
            access(1'b0, 1'b0, 16'h0040, 16'h0000, 3);
            begin
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clk);
                    if (k == 1) begin
                        chk("rd_mem_en",   if1.mem_en, 1);
                        chk("rd_mem_addr", if1.mem_addr, 16'h0040);
                        chk("rd_mem_we",   if1.mem_we, 0);
                    end
                    chk("rd_dbg_gnt", if1.dbg_gnt, 0);
                end
            end
        join
        @(negedge clk);

        // Last winner was the CPU, so this tie goes to debug first.
        fork
            access(1'b1, 1'b0, 16'h0020, 16'h0000, 3);
            access(1'b0, 1'b0, 16'h0010, 16'h0000, 7);
        join
        @(negedge clk);

        // dbg_lock starves a pending CPU read.
        if1.dbg_lock = 1'b1;
        if1.cpu_req = 1'b1; if1.cpu_we = 1'b0; if1.cpu_addr = 16'h0040;
        lock_phase = 1'b1;
        repeat (3) begin
            access(1'b1, 1'b0, 16'h0021, 16'h0000, 3);
            @(negedge clk);
        end
        lock_phase = 1'b0;
        if1.dbg_lock = 1'b0;
        e.cyc = cyc + 3; e.data = shadow[8'h40]; exp_rd[0] = e.data;
        sb_cpu.push_back(e);
        wait_done(1'b0);
        @(negedge clk);

        // Write leaves cpu_rdata alone; read-back returns the write.
        access(1'b0, 1'b1, 16'h0007, 16'hABCD, 2);
        @(negedge clk);
        access(1'b0, 1'b0, 16'h0007, 16'h0000, 3);
        @(negedge clk);

        // Reset during WAIT aborts the read.
        if1.cpu_req = 1'b1; if1.cpu_we = 1'b0; if1.cpu_addr = 16'h0011;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_gnt", if1.cpu_gnt, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cpu_gnt",   if1.cpu_gnt, 0);
        chk("abort_dbg_gnt",   if1.dbg_gnt, 0);
        chk("abort_cpu_done",  if1.cpu_done, 0);
        chk("abort_dbg_done",  if1.dbg_done, 0);
        chk("abort_cpu_rdata", if1.cpu_rdata, 0);
        chk("abort_dbg_rdata", if1.dbg_rdata, 0);
        chk("abort_mem_en",    if1.mem_en, 0);
        chk("abort_mem_we",    if1.mem_we, 0);
        chk("abort_mem_addr",  if1.mem_addr, 0);
        chk("abort_mem_wdata", if1.mem_wdata, 0);
        rst = 1'b0;
        if1.cpu_req = 1'b0;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        @(negedge clk);
        access(1'b0, 1'b0, 16'h0011, 16'h0000, 3);
        @(negedge clk);

        // MEM_LAT=3 debug read with qualifiers changing after grant.
        if3.dbg_req = 1'b1; if3.dbg_we = 1'b0; if3.dbg_addr = 16'h00FF;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("l3_mem_addr", if3.mem_addr, 16'h00FF);
            chk("l3_mem_en",   if3.mem_en, (k == 1) ? 1 : 0);
            chk("l3_dbg_gnt",  if3.dbg_gnt, (k <= 5) ? 1 : 0);
            chk("l3_dbg_done", if3.dbg_done, (k == 5) ? 1 : 0);
            if (k == 5) begin
                chk("l3_dbg_rdata", if3.dbg_rdata, 16'h5A5A);
                if3.dbg_req = 1'b0;
            end
            if3.cpu_addr = 16'(k * 16'h0111);
            if3.dbg_addr = 16'h1234 + 16'(k);
        end

        repeat (2) @(negedge clk);
        chk("sb_cpu_drained", sb_cpu.size(), 0);
        chk("sb_dbg_drained", sb_dbg.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported synchronous data/instruction memory between two requesters: port 0 is the CPU datapath (MEM_read/MEM_write under control-FSM sequencing); port 1 is the debug/program-loader port.
- Arbitrates between the two ports and sequences one memory access at a time.
- Returns read data with a one-cycle done pulse.
- Sits between the CPU core/loader and the memory macro.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata (legal range 1..7)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU owns memory (ACCESS..RESP)
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  registered read data
- dbg_req  in  1  debug access request
- dbg_we  in  1  1=write
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_lock  in  1  when high, CPU requests are never granted
- dbg_gnt  out  1  debug owns memory
- dbg_done  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  registered read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: the following are 0.
  - Registers: state=IDLE, last_q=PORT_DBG, wait counter.
  - Outputs: all *_gnt, *_done, *_rdata and all mem_* outputs.
- Reset mid-transaction aborts it: no done pulse, and rdata is cleared.
- State machine:
  - IDLE
    - Sample requests; eligible = {cpu_req & ~dbg_lock, dbg_req}.
    - None eligible: stay in IDLE.
    - Exactly one eligible: grant it.
    - Both eligible: grant the port != last_q (round-robin), so the CPU wins the first tie after reset.
    - On grant: latch we/addr/wdata of the winner into internal registers, set owner_q and last_q, go to ACCESS.
  - ACCESS (1 cycle)
    - mem_en=1; mem_we/addr/wdata driven from the latched registers.
    - Write: go to RESP.
    - Read: load counter=MEM_LAT-1, go to WAIT.
  - WAIT
    - Decrement the counter.
    - When counter==0, capture mem_rdata into the owner's rdata register and go to RESP.
  - RESP (1 cycle)
    - Owner's done=1, then go to IDLE.
- Latency, from the IDLE cycle that samples req:
  - Write: done at +2.
  - Read: done at +2+MEM_LAT (MEM_LAT=1 → +3).
- Between accesses: minimum one IDLE cycle, so peak throughput is one write per 3 cycles.
- Outputs outside ACCESS: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last values.
- gnt: high for the owner from ACCESS through RESP inclusive; the gnts are mutually exclusive.
- Request protocol:
  - Requester holds req and its qualifiers until done.
  - Qualifier changes after the grant are ignored; values are latched in IDLE.
  - A req still high in the IDLE cycle after done is treated as a new request.
- rdata:
  - Updated only by reads of that port.
  - Held until the next read completion on that port.
  - Unchanged on writes.
- dbg_lock:
  - Sampled only in IDLE.
  - Asserting it mid-transaction does not abort a CPU access.
  - While it is high, the CPU starves with no done.
- Simultaneous events: a req deasserting in the IDLE cycle simply loses eligibility; there is no partial grant.

Decomposition:
- defs_pkg gains:
  - arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_RESP} (logic [1:0])
  - arb_port_t enum {PORT_CPU=1'b0, PORT_DBG=1'b1}
- One sub-module is natural: mem_arb_rr2, a combinational 2-way round-robin pick taking the eligible vector and last_q and returning grant_valid and the winner. The FSM, latching and rdata registers stay in mem_port_arbiter.

Test Plan:
- CPU read, MEM_LAT=1, mem[0x0040]=0xBEEF, cpu_req at cycle 0:
  - cycle 1: mem_en=1, mem_addr=0x0040, mem_we=0
  - cycle 3: cpu_done=1, cpu_rdata=0xBEEF
  - dbg_gnt stays 0 throughout
- Simultaneous cpu_req and dbg_req (writes, 0x1111→0x10 and 0x2222→0x20) immediately after reset:
  - CPU write issued first (done at cycle 2)
  - DBG write next (ACCESS at cycle 4, dbg_done at cycle 5)
  - Next tie grants CPU again.
- dbg_lock=1 with both requesting reads repeatedly:
  - only dbg_done pulses
  - cpu_gnt never asserts
- After dbg_lock drops: CPU is granted on the next IDLE.
- MEM_LAT=3 debug read of 0x00FF (mem=0x5A5A) with cpu_addr toggling during the transaction:
  - dbg_done exactly at cycle 5 with 0x5A5A
  - mem_addr stays 0x00FF throughout
- rst asserted during WAIT of a CPU read:
  - next cycle: all outputs 0, no cpu_done
  - a subsequent read completes normally
- CPU write 0xABCD to 0x0007, then read of 0x0007:
  - cpu_rdata is unchanged after the write
  - after the read: cpu_rdata=0xABCD
